// File: rtl/apb_master_bridge.sv
// APB3 master bridge: command-side requests to NUM_SLV address-decoded APB slaves,
// with wait states and back-to-back transfers. Define APB_TIMEOUT_EN to enable the wait-state timeout.
module apb_master_bridge #(
    parameter int ADDR_W  = 9,
    parameter int DATA_W  = 8,
    parameter int NUM_SLV = 2,
    parameter int TIMEOUT = 16
) (
    input  logic                      PCLK,
    input  logic                      PRESETn,
    input  logic                      transfer,
    input  logic                      READ_WRITE,
    input  logic [ADDR_W-1:0]         apb_write_paddr,
    input  logic [ADDR_W-1:0]         apb_read_paddr,
    input  logic [DATA_W-1:0]         apb_write_data,
    output logic [DATA_W-1:0]         apb_read_data_out,
    output logic                      PSLVERR,
    output logic                      xfer_done,
    output logic [NUM_SLV-1:0]        m_psel,
    output logic                      m_penable,
    output logic                      m_pwrite,
    output logic [ADDR_W-1:0]         m_paddr,
    output logic [DATA_W-1:0]         m_pwdata,
    input  logic [NUM_SLV*DATA_W-1:0] s_prdata,
    input  logic [NUM_SLV-1:0]        s_pready,
    input  logic [NUM_SLV-1:0]        s_pslverr
);

    localparam int SEL_W = (NUM_SLV > 2) ? $clog2(NUM_SLV) : 1;
    localparam logic [SEL_W:0] NUM_SLV_L = (SEL_W + 1)'(NUM_SLV);

    if (NUM_SLV < 2 || NUM_SLV > 16 || TIMEOUT < 1) begin : g_bad_param
        $error("apb_master_bridge: NUM_SLV must be 2..16 and TIMEOUT at least 1");
    end

    typedef enum logic [1:0] {IDLE, SETUP, ACCESS} state_t;

    state_t              state_q, state_d;
    logic [NUM_SLV-1:0]  psel_q, psel_d;
    logic                penable_q, penable_d;
    logic                pwrite_q, pwrite_d;
    logic [ADDR_W-1:0]   paddr_q, paddr_d;
    logic [DATA_W-1:0]   pwdata_q, pwdata_d;
    logic [DATA_W-1:0]   rdata_q, rdata_d;
    logic                pslverr_q, pslverr_d;
    logic                done_q, done_d;

`ifdef APB_TIMEOUT_EN
    localparam int CNT_W = $clog2(TIMEOUT + 1);
    localparam logic [CNT_W-1:0] TO_LAST = CNT_W'(TIMEOUT - 1);
    logic [CNT_W-1:0]    cnt_q, cnt_d;
`endif

    logic [ADDR_W-1:0]   cmd_addr;
    logic [SEL_W-1:0]    cmd_idx;
    logic                cmd_ok;
    logic [NUM_SLV-1:0]  cmd_sel;
    logic                sel_pready;
    logic                sel_pslverr;
    logic [DATA_W-1:0]   sel_prdata;
    logic                take_cmd;

    // Command decode; an index past the last slave is a decode error.
    always_comb begin
        cmd_addr = READ_WRITE ? apb_write_paddr : apb_read_paddr;
        cmd_idx  = cmd_addr[ADDR_W-1 -: SEL_W];
        cmd_ok   = {1'b0, cmd_idx} < NUM_SLV_L;
        cmd_sel  = '0;
        for (int i = 0; i < NUM_SLV; i++) begin
            cmd_sel[i] = (cmd_idx == i[SEL_W-1:0]);
        end
    end

    // The registered one-hot select doubles as the response mux control.
    always_comb begin
        sel_pready  = |(s_pready & psel_q);
        sel_pslverr = |(s_pslverr & psel_q);
        sel_prdata  = '0;
        for (int i = 0; i < NUM_SLV; i++) begin
            if (psel_q[i]) sel_prdata = sel_prdata | s_prdata[i*DATA_W +: DATA_W];
        end
    end

    always_comb begin
        state_d   = state_q;
        psel_d    = psel_q;
        penable_d = penable_q;
        pwrite_d  = pwrite_q;
        paddr_d   = paddr_q;
        pwdata_d  = pwdata_q;
        rdata_d   = rdata_q;
        pslverr_d = pslverr_q;
        done_d    = 1'b0;
        take_cmd  = 1'b0;
`ifdef APB_TIMEOUT_EN
        cnt_d     = cnt_q;
`endif
        case (state_q)
            IDLE: begin
                if (transfer) begin
                    if (cmd_ok) begin
                        take_cmd = 1'b1;
                    end else begin
                        pslverr_d = 1'b1;
                        done_d    = 1'b1;
                    end
                end
            end
            SETUP: begin
                penable_d = 1'b1;
                state_d   = ACCESS;
`ifdef APB_TIMEOUT_EN
                cnt_d     = '0;
`endif
            end
            ACCESS: begin
                if (sel_pready) begin
                    done_d    = 1'b1;
                    pslverr_d = sel_pslverr;
                    if (!pwrite_q) rdata_d = sel_pslverr ? '0 : sel_prdata;
                    penable_d = 1'b0;
                    psel_d    = '0;
                    state_d   = IDLE;
                    // A bad address here is left for IDLE to report on the next edge.
                    if (transfer && cmd_ok) take_cmd = 1'b1;
                end
`ifdef APB_TIMEOUT_EN
                else if (cnt_q == TO_LAST) begin
                    done_d    = 1'b1;
                    pslverr_d = 1'b1;
                    if (!pwrite_q) rdata_d = '0;
                    penable_d = 1'b0;
                    psel_d    = '0;
                    state_d   = IDLE;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
`endif
            end
            default: state_d = IDLE;
        endcase
        if (take_cmd) begin
            pwrite_d = READ_WRITE;
            paddr_d  = cmd_addr;
            pwdata_d = apb_write_data;
            psel_d   = cmd_sel;
            state_d  = SETUP;
        end
    end

    always_ff @(posedge PCLK or negedge PRESETn) begin
        if (!PRESETn) begin
            state_q   <= IDLE;
            psel_q    <= '0;
            penable_q <= 1'b0;
            pwrite_q  <= 1'b0;
            paddr_q   <= '0;
            pwdata_q  <= '0;
            rdata_q   <= '0;
            pslverr_q <= 1'b0;
            done_q    <= 1'b0;
`ifdef APB_TIMEOUT_EN
            cnt_q     <= '0;
`endif
        end else begin
            state_q   <= state_d;
            psel_q    <= psel_d;
            penable_q <= penable_d;
            pwrite_q  <= pwrite_d;
            paddr_q   <= paddr_d;
            pwdata_q  <= pwdata_d;
            rdata_q   <= rdata_d;
            pslverr_q <= pslverr_d;
            done_q    <= done_d;
`ifdef APB_TIMEOUT_EN
            cnt_q     <= cnt_d;
`endif
        end
    end

    assign apb_read_data_out = rdata_q;
    assign PSLVERR           = pslverr_q;
    assign xfer_done         = done_q;
    assign m_psel            = psel_q;
    assign m_penable         = penable_q;
    assign m_pwrite          = pwrite_q;
    assign m_paddr           = paddr_q;
    assign m_pwdata          = pwdata_q;

endmodule

// File: tb/tb_apb_master_bridge.sv
// Directed bench for apb_master_bridge with three slaves (address bits [8:7] select the slave).
module tb_apb_master_bridge;

    localparam int ADDR_W  = 9;
    localparam int DATA_W  = 8;
    localparam int NUM_SLV = 3;
    localparam int TIMEOUT = 16;

    logic                      PCLK = 1'b0;
    logic                      PRESETn = 1'b0;
    logic                      transfer = 1'b0;
    logic                      READ_WRITE = 1'b0;
    logic [ADDR_W-1:0]         apb_write_paddr = '0;
    logic [ADDR_W-1:0]         apb_read_paddr = '0;
    logic [DATA_W-1:0]         apb_write_data = '0;
    logic [DATA_W-1:0]         apb_read_data_out;
    logic                      PSLVERR;
    logic                      xfer_done;
    logic [NUM_SLV-1:0]        m_psel;
    logic                      m_penable;
    logic                      m_pwrite;
    logic [ADDR_W-1:0]         m_paddr;
    logic [DATA_W-1:0]         m_pwdata;
    logic [NUM_SLV*DATA_W-1:0] s_prdata = '0;
    logic [NUM_SLV-1:0]        s_pready = '0;
    logic [NUM_SLV-1:0]        s_pslverr = '0;

    apb_master_bridge #(
        .ADDR_W(ADDR_W), .DATA_W(DATA_W), .NUM_SLV(NUM_SLV), .TIMEOUT(TIMEOUT)
    ) dut (
        .PCLK(PCLK), .PRESETn(PRESETn), .transfer(transfer), .READ_WRITE(READ_WRITE),
        .apb_write_paddr(apb_write_paddr), .apb_read_paddr(apb_read_paddr),
        .apb_write_data(apb_write_data), .apb_read_data_out(apb_read_data_out),
        .PSLVERR(PSLVERR), .xfer_done(xfer_done), .m_psel(m_psel), .m_penable(m_penable),
        .m_pwrite(m_pwrite), .m_paddr(m_paddr), .m_pwdata(m_pwdata),
        .s_prdata(s_prdata), .s_pready(s_pready), .s_pslverr(s_pslverr)
    );

    always #5 PCLK = ~PCLK;

    int passed = 0;
    int total  = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act === exp) passed++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    endtask

    // exp_slv = 3 marks a decode error; exp_lat counts edges from the sampling edge to completion.
    typedef struct {
        logic              rw;
        logic [ADDR_W-1:0] waddr;
        logic [ADDR_W-1:0] raddr;
        logic [DATA_W-1:0] wdata;
        logic [DATA_W-1:0] prd;
        int                waits;
        logic              err;
        int                exp_slv;
        logic              exp_err;
        logic [DATA_W-1:0] exp_rdata;
        int                exp_lat;
    } vec_t;

    vec_t vecs[8];

    task automatic run_vec(input vec_t v, input int n);
        int cycles, setups, accs;
        logic seen_done, held_bad, ready;
        logic [NUM_SLV-1:0] mask;
        logic [ADDR_W-1:0] exp_addr;
        string tag;
        tag = $sformatf("v%0d", n);
        mask = '0;
        if (v.exp_slv < NUM_SLV) mask[v.exp_slv] = 1'b1;
        exp_addr = v.rw ? v.waddr : v.raddr;
        for (int i = 0; i < NUM_SLV; i++)
            s_prdata[i*DATA_W +: DATA_W] = (i == v.exp_slv) ? v.prd : 8'hEE;
        @(negedge PCLK);
        transfer = 1'b1; READ_WRITE = v.rw; apb_write_paddr = v.waddr;
        apb_read_paddr = v.raddr; apb_write_data = v.wdata;
        s_pready = '0; s_pslverr = '0;
        cycles = 0; setups = 0; accs = 0; seen_done = 0; held_bad = 0;
        while (!seen_done && cycles < 40) begin
            @(negedge PCLK);
            cycles++;
            transfer = 1'b0; READ_WRITE = ~v.rw;
            apb_write_paddr = ~v.waddr; apb_read_paddr = ~v.raddr; apb_write_data = ~v.wdata;
            if (xfer_done) begin
                seen_done = 1;
            end else if (m_psel != '0 && !m_penable) begin
                setups++;
            end else if (m_penable) begin
                accs++;
                ready = (accs > v.waits);
                s_pready  = ready ? '1 : ~mask;
                s_pslverr = ready ? (v.err ? '1 : ~mask) : '1;
            end
            if ((m_psel != '0 || m_penable) &&
                (m_psel !== mask || m_paddr !== exp_addr || m_pwrite !== v.rw ||
                 (v.rw && m_pwdata !== v.wdata)))
                held_bad = 1;
        end
        chk({tag, "_done_seen"}, 32'(seen_done), 32'd1);
        chk({tag, "_latency"}, 32'(cycles), 32'(v.exp_lat));
        chk({tag, "_setup_cycles"}, 32'(setups), (mask != '0) ? 32'd1 : 32'd0);
        chk({tag, "_access_cycles"}, 32'(accs), (mask != '0) ? 32'(v.waits + 1) : 32'd0);
        chk({tag, "_bus_stable"}, 32'(held_bad), 32'd0);
        chk({tag, "_pslverr"}, 32'(PSLVERR), 32'(v.exp_err));
        chk({tag, "_rdata"}, 32'(apb_read_data_out), 32'(v.exp_rdata));
        chk({tag, "_psel_idle"}, 32'(m_psel), 32'd0);
        chk({tag, "_penable_idle"}, 32'(m_penable), 32'd0);
        s_pready = '0; s_pslverr = '0;
        @(negedge PCLK);
        chk({tag, "_done_pulse"}, 32'(xfer_done), 32'd0);
    endtask

    initial begin
        //        rw    waddr    raddr    wdata  prd    wt err slv e_err e_rdata lat
        vecs[0] = '{1'b1, 9'h005, 9'h185, 8'hA5, 8'h00, 0, 1'b0, 0, 1'b0, 8'h00, 3};
        vecs[1] = '{1'b0, 9'h1C0, 9'h085, 8'h00, 8'h3C, 3, 1'b0, 1, 1'b0, 8'h3C, 6};
        vecs[2] = '{1'b1, 9'h105, 9'h000, 8'h5A, 8'h00, 2, 1'b0, 2, 1'b0, 8'h3C, 5};
        vecs[3] = '{1'b0, 9'h100, 9'h010, 8'h00, 8'h77, 1, 1'b1, 0, 1'b1, 8'h00, 4};
        vecs[4] = '{1'b1, 9'h0FF, 9'h1C0, 8'hC3, 8'h00, 0, 1'b0, 1, 1'b0, 8'h00, 3};
        vecs[5] = '{1'b0, 9'h1C0, 9'h17F, 8'h00, 8'h96, 0, 1'b0, 2, 1'b0, 8'h96, 3};
        vecs[6] = '{1'b0, 9'h000, 9'h1C0, 8'h00, 8'h00, 0, 1'b0, 3, 1'b1, 8'h96, 1};
        vecs[7] = '{1'b1, 9'h1FF, 9'h000, 8'h44, 8'h00, 0, 1'b0, 3, 1'b1, 8'h96, 1};

        repeat (2) @(negedge PCLK);
        chk("rst_psel", 32'(m_psel), 32'd0);
        chk("rst_penable", 32'(m_penable), 32'd0);
        chk("rst_pslverr", 32'(PSLVERR), 32'd0);
        chk("rst_rdata", 32'(apb_read_data_out), 32'd0);
        chk("rst_done", 32'(xfer_done), 32'd0);
        chk("rst_paddr", 32'(m_paddr), 32'd0);
        chk("rst_pwdata", 32'(m_pwdata), 32'd0);
        chk("rst_pwrite", 32'(m_pwrite), 32'd0);
        PRESETn = 1'b1;

        for (int k = 0; k < 8; k++) run_vec(vecs[k], k);

        // Reset in the middle of a stalled access (PSLVERR=1, read data 0x96 beforehand).
        @(negedge PCLK);
        transfer = 1'b1; READ_WRITE = 1'b0; apb_read_paddr = 9'h085; s_pready = '0;
        @(negedge PCLK);
        transfer = 1'b0;
        @(negedge PCLK);
        chk("mrst_in_access", 32'(m_penable), 32'd1);
        #2 PRESETn = 1'b0;
        #1;
        chk("mrst_psel", 32'(m_psel), 32'd0);
        chk("mrst_penable", 32'(m_penable), 32'd0);
        chk("mrst_pslverr", 32'(PSLVERR), 32'd0);
        chk("mrst_rdata", 32'(apb_read_data_out), 32'd0);
        chk("mrst_done", 32'(xfer_done), 32'd0);
        s_pready = '1;
        @(negedge PCLK);
        chk("mrst_done_held", 32'(xfer_done), 32'd0);
        PRESETn = 1'b1;
        @(negedge PCLK);
        chk("mrst_done_after", 32'(xfer_done), 32'd0);
        chk("mrst_psel_after", 32'(m_psel), 32'd0);
        s_pready = '0;

        // Back-to-back writes: slave 0 then slave 1 with transfer held high.
        @(negedge PCLK);
        transfer = 1'b1; READ_WRITE = 1'b1; apb_write_paddr = 9'h011; apb_write_data = 8'h11;
        @(negedge PCLK);
        chk("b2b_setup1_psel", 32'(m_psel), 32'b001);
        apb_write_paddr = 9'h091; apb_write_data = 8'h22;
        @(negedge PCLK);
        chk("b2b_access1_penable", 32'(m_penable), 32'd1);
        chk("b2b_access1_paddr", 32'(m_paddr), 32'h011);
        chk("b2b_access1_pwdata", 32'(m_pwdata), 32'h11);
        s_pready = '1;
        @(negedge PCLK);
        chk("b2b_done1", 32'(xfer_done), 32'd1);
        chk("b2b_setup2_psel", 32'(m_psel), 32'b010);
        chk("b2b_setup2_penable", 32'(m_penable), 32'd0);
        chk("b2b_setup2_paddr", 32'(m_paddr), 32'h091);
        chk("b2b_setup2_pwdata", 32'(m_pwdata), 32'h22);
        transfer = 1'b0; s_pready = '0;
        @(negedge PCLK);
        chk("b2b_gap_done", 32'(xfer_done), 32'd0);
        chk("b2b_access2_penable", 32'(m_penable), 32'd1);
        s_pready = '1;
        @(negedge PCLK);
        chk("b2b_done2", 32'(xfer_done), 32'd1);
        chk("b2b_psel_end", 32'(m_psel), 32'd0);
        chk("b2b_pslverr", 32'(PSLVERR), 32'd0);
        s_pready = '0;

`ifdef APB_TIMEOUT_EN
        begin
            int cyc;
            @(negedge PCLK);
            transfer = 1'b1; READ_WRITE = 1'b0; apb_read_paddr = 9'h010;
            s_prdata = {NUM_SLV{8'h55}}; s_pready = '0;
            cyc = 0;
            do begin
                @(negedge PCLK);
                transfer = 1'b0;
                cyc++;
            end while (!xfer_done && cyc < 60);
            chk("to_latency", 32'(cyc), 32'(2 + TIMEOUT));
            chk("to_pslverr", 32'(PSLVERR), 32'd1);
            chk("to_rdata", 32'(apb_read_data_out), 32'd0);
            chk("to_psel", 32'(m_psel), 32'd0);
            chk("to_penable", 32'(m_penable), 32'd0);
        end
`endif

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
